rggen_axi4lite_bridge: RTL and testbench

Initiator-side counterpart of the AXI4-Lite register adapter: accepts one rggen internal bus request (valid/access/address/write_data/strobe) and issues it as a single AXI4-Lite master transaction, returning ready/status/read_data when the AXI response arrives. It sits between an rggen-style requester (CPU shim, test sequencer, chained register block) and any AXI4-Lite subordinate. It handles one outstanding transaction at a time.

---
 rtl/rggen_axi4lite_bridge_pkg.sv | 30 +++
 rtl/rggen_axi4lite_bridge.sv | 193 +++++++++++++++++++
 tb/tb_rggen_axi4lite_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_axi4lite_bridge_pkg.sv
// Shared rggen access codes, AXI response codes and bridge state encoding.
package rggen_axi4lite_bridge_pkg;

   localparam logic [1:0] RGGEN_WRITE = 2'b11;
   localparam logic [1:0] RGGEN_READ  = 2'b10;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_SLVERR = 2'b10;
   localparam logic [1:0] AXI_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE          = 2'b00,
      ST_WRITE_REQUEST = 2'b01,
      ST_READ_REQUEST  = 2'b10,
      ST_WAIT_RESPONSE = 2'b11
   } bridge_state_e;

   // Anything that is not an explicit write is issued as a read.
   function automatic logic is_write(input logic [1:0] access);
      logic result;
      case (access)
         RGGEN_WRITE: result = 1'b1;
         RGGEN_READ:  result = 1'b0;
         default:     result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/rggen_axi4lite_bridge.sv
// Converts one rggen bus request into a single AXI4-Lite master transaction,
// one outstanding transaction at a time.
module rggen_axi4lite_bridge
   import rggen_axi4lite_bridge_pkg::*;
#(
   parameter int         ID_WIDTH        = 0,
   parameter int         ADDRESS_WIDTH   = 8,
   parameter int         BUS_WIDTH       = 32,
   parameter int         ID_VALUE        = 0,
   parameter logic [2:0] PROT_VALUE      = 3'b000,
   parameter int         ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1
)(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_bus_valid,
   input  logic [1:0]                 i_bus_access,
   input  logic [ADDRESS_WIDTH-1:0]   i_bus_address,
   input  logic [BUS_WIDTH-1:0]       i_bus_write_data,
   input  logic [BUS_WIDTH/8-1:0]     i_bus_strobe,
   output logic                       o_bus_ready,
   output logic [1:0]                 o_bus_status,
   output logic [BUS_WIDTH-1:0]       o_bus_read_data,
   output logic                       o_awvalid,
   input  logic                       i_awready,
   output logic [ACTUAL_ID_WIDTH-1:0] o_awid,
   output logic [ADDRESS_WIDTH-1:0]   o_awaddr,
   output logic [2:0]                 o_awprot,
   output logic                       o_wvalid,
   input  logic                       i_wready,
   output logic [BUS_WIDTH-1:0]       o_wdata,
   output logic [BUS_WIDTH/8-1:0]     o_wstrb,
   input  logic                       i_bvalid,
   output logic                       o_bready,
   input  logic [ACTUAL_ID_WIDTH-1:0] i_bid,
   input  logic [1:0]                 i_bresp,
   output logic                       o_arvalid,
   input  logic                       i_arready,
   output logic [ACTUAL_ID_WIDTH-1:0] o_arid,
   output logic [ADDRESS_WIDTH-1:0]   o_araddr,
   output logic [2:0]                 o_arprot,
   input  logic                       i_rvalid,
   output logic                       o_rready,
   input  logic [ACTUAL_ID_WIDTH-1:0] i_rid,
   input  logic [1:0]                 i_rresp,
   input  logic [BUS_WIDTH-1:0]       i_rdata
);

   localparam logic [ACTUAL_ID_WIDTH-1:0] ID_CONST =
      (ID_WIDTH > 0) ? ACTUAL_ID_WIDTH'(ID_VALUE) : '0;

   bridge_state_e              state_r;
   bridge_state_e              state_next_s;
   logic [1:0]                 access_r;
   logic [ADDRESS_WIDTH-1:0]   address_r;
   logic [BUS_WIDTH-1:0]       write_data_r;
   logic [BUS_WIDTH/8-1:0]     strobe_r;
   logic                       aw_done_r;
   logic                       w_done_r;
   logic                       aw_done_next_s;
   logic                       w_done_next_s;
   logic                       capture_s;
   logic                       awvalid_s;
   logic                       wvalid_s;
   logic                       arvalid_s;
   logic                       bready_s;
   logic                       rready_s;
   logic                       bus_ready_s;
   logic [1:0]                 bus_status_s;
   logic [BUS_WIDTH-1:0]       bus_read_data_s;

   // Response IDs are not checked since only one transaction is ever outstanding.
   logic unused_s;
   assign unused_s = ^{i_bid, i_rid};

   // State register, request capture and per-channel write handshake flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= ST_IDLE;
         access_r     <= 2'b00;
         address_r    <= '0;
         write_data_r <= '0;
         strobe_r     <= '0;
         aw_done_r    <= 1'b0;
         w_done_r     <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         aw_done_r <= aw_done_next_s;
         w_done_r  <= w_done_next_s;
         if (capture_s) begin
            access_r     <= i_bus_access;
            address_r    <= i_bus_address;
            write_data_r <= i_bus_write_data;
            strobe_r     <= i_bus_strobe;
         end
      end
   end

   // Next-state decode plus AXI valid/ready and completion outputs.
   always_comb begin
      state_next_s    = state_r;
      capture_s       = 1'b0;
      aw_done_next_s  = aw_done_r;
      w_done_next_s   = w_done_r;
      awvalid_s       = 1'b0;
      wvalid_s        = 1'b0;
      arvalid_s       = 1'b0;
      bready_s        = 1'b0;
      rready_s        = 1'b0;
      bus_ready_s     = 1'b0;
      bus_status_s    = AXI_OKAY;
      bus_read_data_s = '0;
      case (state_r)
         ST_IDLE: begin
            aw_done_next_s = 1'b0;
            w_done_next_s  = 1'b0;
            if (i_bus_valid) begin
               capture_s = 1'b1;
               if (is_write(i_bus_access)) begin
                  state_next_s = ST_WRITE_REQUEST;
               end else begin
                  state_next_s = ST_READ_REQUEST;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WRITE_REQUEST: begin
            // Each channel's valid drops independently once its handshake is done.
            awvalid_s      = !aw_done_r;
            wvalid_s       = !w_done_r;
            aw_done_next_s = aw_done_r | i_awready;
            w_done_next_s  = w_done_r | i_wready;
            if (aw_done_next_s && w_done_next_s) begin
               state_next_s = ST_WAIT_RESPONSE;
            end else begin
               state_next_s = ST_WRITE_REQUEST;
            end
         end
         ST_READ_REQUEST: begin
            arvalid_s = 1'b1;
            if (i_arready) begin
               state_next_s = ST_WAIT_RESPONSE;
            end else begin
               state_next_s = ST_READ_REQUEST;
            end
         end
         ST_WAIT_RESPONSE: begin
            if (is_write(access_r)) begin
               bready_s = 1'b1;
               if (i_bvalid) begin
                  bus_ready_s  = 1'b1;
                  bus_status_s = i_bresp;
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = ST_WAIT_RESPONSE;
               end
            end else begin
               rready_s = 1'b1;
               if (i_rvalid) begin
                  bus_ready_s     = 1'b1;
                  bus_status_s    = i_rresp;
                  bus_read_data_s = i_rdata;
                  state_next_s    = ST_IDLE;
               end else begin
                  state_next_s = ST_WAIT_RESPONSE;
               end
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   assign o_bus_ready     = bus_ready_s;
   assign o_bus_status    = bus_status_s;
   assign o_bus_read_data = bus_read_data_s;

   assign o_awvalid = awvalid_s;
   assign o_awid    = ID_CONST;
   assign o_awaddr  = address_r;
   assign o_awprot  = PROT_VALUE;
   assign o_wvalid  = wvalid_s;
   assign o_wdata   = write_data_r;
   assign o_wstrb   = strobe_r;
   assign o_bready  = bready_s;
   assign o_arvalid = arvalid_s;
   assign o_arid    = ID_CONST;
   assign o_araddr  = address_r;
   assign o_arprot  = PROT_VALUE;
   assign o_rready  = rready_s;

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed self-checking bench for rggen_axi4lite_bridge (ID_WIDTH=4, ID_VALUE=9).
module tb_rggen_axi4lite_bridge;
   import rggen_axi4lite_bridge_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        bus_valid;
   logic [1:0]  bus_access;
   logic [7:0]  bus_address;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_strobe;
   logic        bus_ready;
   logic [1:0]  bus_status;
   logic [31:0] bus_read_data;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [3:0]  awid, arid, bid, rid;
   logic [7:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks = 0;
   int errors = 0;
   int n_ready = 0;
   int base;

   rggen_axi4lite_bridge #(
      .ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .ID_VALUE(9), .PROT_VALUE(3'b000)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_bus_valid(bus_valid), .i_bus_access(bus_access), .i_bus_address(bus_address),
      .i_bus_write_data(bus_write_data), .i_bus_strobe(bus_strobe),
      .o_bus_ready(bus_ready), .o_bus_status(bus_status), .o_bus_read_data(bus_read_data),
      .o_awvalid(awvalid), .i_awready(awready), .o_awid(awid), .o_awaddr(awaddr), .o_awprot(awprot),
      .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
      .i_bvalid(bvalid), .o_bready(bready), .i_bid(bid), .i_bresp(bresp),
      .o_arvalid(arvalid), .i_arready(arready), .o_arid(arid), .o_araddr(araddr), .o_arprot(arprot),
      .i_rvalid(rvalid), .o_rready(rready), .i_rid(rid), .i_rresp(rresp), .i_rdata(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus_ready === 1'b1) n_ready++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic request(input logic [1:0] acc, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
      bus_valid      = 1'b1;
      bus_access     = acc;
      bus_address    = addr;
      bus_write_data = data;
      bus_strobe     = strb;
   endtask

   task automatic clear_inputs();
      bus_valid = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0; bid = 4'h0; rid = 4'h0;
      bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus_access = 2'b00; bus_address = 8'h00; bus_write_data = 32'h0; bus_strobe = 4'h0;
      clear_inputs();
      next_cycle();
      next_cycle();
      settle();
      check("rst_awvalid", awvalid, 1'b0);
      check("rst_wvalid", wvalid, 1'b0);
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_bready", bready, 1'b0);
      check("rst_rready", rready, 1'b0);
      check("rst_bus_ready", bus_ready, 1'b0);
      check("rst_awaddr", awaddr, 8'h00);
      check("rst_araddr", araddr, 8'h00);
      check("rst_wdata", wdata, 32'h0);
      check("rst_wstrb", wstrb, 4'h0);
      next_cycle();
      rst_n = 1'b1;

      // Write, both readies in the same cycle, response immediately.
      next_cycle();
      base = n_ready;
      request(RGGEN_WRITE, 8'h10, 32'hA5A5_0001, 4'hF);
      awready = 1'b1; wready = 1'b1;
      next_cycle();
      settle();
      check("w1_awvalid", awvalid, 1'b1);
      check("w1_wvalid", wvalid, 1'b1);
      check("w1_awaddr", awaddr, 8'h10);
      check("w1_wdata", wdata, 32'hA5A5_0001);
      check("w1_wstrb", wstrb, 4'hF);
      check("w1_awid", awid, 4'h9);
      check("w1_awprot", awprot, 3'b000);
      check("w1_ready_c1", bus_ready, 1'b0);
      next_cycle();
      bvalid = 1'b1; bresp = AXI_OKAY;
      settle();
      check("w1_bready", bready, 1'b1);
      check("w1_awvalid_c2", awvalid, 1'b0);
      check("w1_bus_ready", bus_ready, 1'b1);
      check("w1_status", bus_status, 2'b00);
      check("w1_rdata", bus_read_data, 32'h0);
      next_cycle();
      clear_inputs();
      settle();
      check("w1_ready_c3", bus_ready, 1'b0);
      check("w1_bready_c3", bready, 1'b0);
      check("w1_pulses", n_ready - base, 1);

      // Write, W handshake three cycles before AW.
      next_cycle();
      base = n_ready;
      request(RGGEN_WRITE, 8'h20, 32'h0BAD_F00D, 4'h3);
      next_cycle();
      wready = 1'b1;
      settle();
      check("w2_awvalid_c1", awvalid, 1'b1);
      check("w2_wvalid_c1", wvalid, 1'b1);
      next_cycle();
      wready = 1'b0;
      bus_address = 8'hEE;
      settle();
      check("w2_wvalid_c2", wvalid, 1'b0);
      check("w2_awvalid_c2", awvalid, 1'b1);
      check("w2_awaddr_held", awaddr, 8'h20);
      next_cycle();
      settle();
      check("w2_awvalid_c3", awvalid, 1'b1);
      next_cycle();
      awready = 1'b1;
      settle();
      check("w2_bready_c4", bready, 1'b0);
      next_cycle();
      awready = 1'b0;
      bvalid = 1'b1; bid = 4'h3; bresp = AXI_EXOKAY;
      settle();
      check("w2_awvalid_c5", awvalid, 1'b0);
      check("w2_bready", bready, 1'b1);
      check("w2_bus_ready", bus_ready, 1'b1);
      check("w2_status", bus_status, 2'b01);
      next_cycle();
      clear_inputs();
      settle();
      check("w2_ready_after", bus_ready, 1'b0);
      check("w2_pulses", n_ready - base, 1);

      // Read with arready delayed two cycles, SLVERR response.
      next_cycle();
      request(RGGEN_READ, 8'h24, 32'h0, 4'h0);
      next_cycle();
      settle();
      check("r1_arvalid_c1", arvalid, 1'b1);
      check("r1_araddr", araddr, 8'h24);
      check("r1_arid", arid, 4'h9);
      check("r1_arprot", arprot, 3'b000);
      check("r1_awvalid", awvalid, 1'b0);
      next_cycle();
      settle();
      check("r1_arvalid_c2", arvalid, 1'b1);
      check("r1_rready_c2", rready, 1'b0);
      next_cycle();
      arready = 1'b1;
      next_cycle();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h1234_5678; rresp = AXI_SLVERR; rid = 4'h5;
      settle();
      check("r1_arvalid_c4", arvalid, 1'b0);
      check("r1_rready", rready, 1'b1);
      check("r1_bus_ready", bus_ready, 1'b1);
      check("r1_status", bus_status, 2'b10);
      check("r1_rdata", bus_read_data, 32'h1234_5678);

      // Back-to-back write; spurious read response while waiting for B.
      next_cycle();
      clear_inputs();
      request(RGGEN_WRITE, 8'h40, 32'h1111_2222, 4'hC);
      awready = 1'b1; wready = 1'b1;
      next_cycle();
      settle();
      check("s_ready_c1", bus_ready, 1'b0);
      check("s_awvalid_c1", awvalid, 1'b1);
      next_cycle();
      awready = 1'b0; wready = 1'b0;
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = AXI_DECERR;
      settle();
      check("s_rready", rready, 1'b0);
      check("s_bready", bready, 1'b1);
      check("s_bus_ready_c2", bus_ready, 1'b0);
      next_cycle();
      settle();
      check("s_bus_ready_c3", bus_ready, 1'b0);
      next_cycle();
      bvalid = 1'b1; bresp = AXI_DECERR;
      settle();
      check("s_bus_ready", bus_ready, 1'b1);
      check("s_status", bus_status, 2'b11);
      check("s_rdata_zero", bus_read_data, 32'h0);
      check("s_rready_c4", rready, 1'b0);
      next_cycle();
      clear_inputs();

      // Reset while AW/W are pending, then a normal read.
      request(RGGEN_WRITE, 8'h50, 32'h0000_0055, 4'h1);
      next_cycle();
      bus_valid = 1'b0;
      settle();
      check("x_awvalid_before", awvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("x_awvalid_async", awvalid, 1'b0);
      check("x_awaddr_async", awaddr, 8'h00);
      next_cycle();
      settle();
      check("x_awvalid", awvalid, 1'b0);
      check("x_wvalid", wvalid, 1'b0);
      check("x_arvalid", arvalid, 1'b0);
      check("x_bready", bready, 1'b0);
      check("x_rready", rready, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      request(RGGEN_READ, 8'h30, 32'h0, 4'h0);
      arready = 1'b1;
      next_cycle();
      settle();
      check("x_r_arvalid", arvalid, 1'b1);
      check("x_r_araddr", araddr, 8'h30);
      next_cycle();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'hCAFE_0042; rresp = AXI_OKAY;
      settle();
      check("x_r_bus_ready", bus_ready, 1'b1);
      check("x_r_status", bus_status, 2'b00);
      check("x_r_rdata", bus_read_data, 32'hCAFE_0042);
      next_cycle();
      clear_inputs();
      settle();
      check("x_r_ready_after", bus_ready, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
